// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and default sizes for the burst memory controller.
package mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // Request descriptor at the default sizes; used by benches to build stimulus.
    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
    } req_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Request / write-beat / read-beat channels of the burst memory controller.
interface mem_burst_ctrl_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy
    );

endinterface

// File: rtl/mem_burst_ctrl_array.sv
// Storage: synchronous write port, combinational read port, no reset.
module mem_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller: accepts one request at a time, then streams write or
// read beats at incrementing (wrapping) addresses, one per clock.
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_burst_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_READ  = READ;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] rdata;

    logic in_write, in_read, in_idle;
    logic req_fire, wr_fire, rd_fire, last_beat;

    // Any encoding other than WRITE/READ behaves as IDLE.
    assign in_write  = (state == ST_WRITE);
    assign in_read   = (state == ST_READ);
    assign in_idle   = !in_write && !in_read;

    assign req_fire  = in_idle  && bus.req_valid;
    assign wr_fire   = in_write && bus.wr_valid;
    assign rd_fire   = in_read  && bus.rd_ready;
    assign last_beat = (beat_cnt == '0);

    assign bus.req_ready = in_idle;
    assign bus.wr_ready  = in_write;
    assign bus.rd_valid  = in_read;
    assign bus.rd_last   = in_read && last_beat;
    // Memory is not reset, so mask read data outside READ.
    assign bus.rd_data   = in_read ? rdata : '0;
    assign bus.busy      = !in_idle;

    // FSM, address pointer and remaining-beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            beat_cnt <= '0;
        end else if (req_fire) begin
            cur_addr <= bus.req_addr;
            beat_cnt <= bus.req_len;
            state    <= bus.req_write ? ST_WRITE : ST_READ;
        end else if (wr_fire || rd_fire) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (last_beat) state    <= ST_IDLE;
            else           beat_cnt <= beat_cnt - LEN_W'(1);
        end else if (in_idle) begin
            state <= ST_IDLE;
        end
    end

    // A beat presented in the same cycle as reset is dropped.
    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (wr_fire && rst_n),
        .waddr (cur_addr),
        .wdata (bus.wr_data),
        .raddr (cur_addr),
        .rdata (rdata)
    );

endmodule
